// File: rtl/rand_delay_pkg.sv
// Shared types and LFSR step function for the random-delay stream element.
package rand_delay_pkg;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [15:0] lfsr_t;

  // Galois form, shifting right; the taps are folded in when a 1 falls out of bit 0.
  function automatic lfsr_t lfsr_next(lfsr_t cur);
    lfsr_t nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ LFSR_MASK;
    return nxt;
  endfunction

endpackage

// File: rtl/rand_delay_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every clock out of reset so that a
// run is reproducible for a given seed regardless of traffic.
module rand_delay_lfsr
  import rand_delay_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_ni,
  output logic [15:0] state
);

  // An all-zero state never leaves zero, so a zero seed is bumped to 1.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  lfsr_t lfsr_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/rand_delay_stream.sv
// Random-delay element for valid/ready streams: every accepted beat is held for a
// per-beat delay before release, in strict FIFO order, with up to DEPTH in flight.
module rand_delay_stream
  import rand_delay_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 8,
  parameter int          MIN_DELAY   = 0,
  parameter int          MAX_DELAY   = 15,
  parameter bit          FIXED_DELAY = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int REM_W = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
  localparam int RANGE = MAX_DELAY - MIN_DELAY + 1;
  localparam bit USE_FIXED = FIXED_DELAY || (MIN_DELAY == MAX_DELAY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (MAX_DELAY < MIN_DELAY) begin : g_bad_range
    $error("rand_delay_stream: MAX_DELAY (%0d) is below MIN_DELAY (%0d)", MAX_DELAY, MIN_DELAY);
  end

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [REM_W-1:0]      mem_rem  [DEPTH];
  logic [DEPTH-1:0]      occupied;
  logic [DEPTH-1:0]      due;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  started;
  lfsr_t                 lfsr_state;
  logic [REM_W-1:0]      new_delay;
  logic                  push;
  logic                  pop;

  rand_delay_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_ni (rst_ni),
    .state  (lfsr_state)
  );

  always_comb begin
    new_delay = REM_W'(MIN_DELAY);
    if (!USE_FIXED) begin
      new_delay = REM_W'(MIN_DELAY) + REM_W'(lfsr_state % 16'(RANGE));
    end
  end

  // started keeps in_ready low until the first edge after reset is released.
  assign in_ready_o  = started & (count < CNT_W'(DEPTH));
  assign out_valid_o = (count != '0) & due[rd_ptr];
  assign out_data_o  = mem_data[rd_ptr];
  assign count_o     = count;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // An entry becomes due one edge after its countdown hits zero, which gives the
  // registered one-cycle minimum latency; due stays set until the entry is popped.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_rem[i]  <= '0;
      end
      occupied <= '0;
      due      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[i]) begin
          if (mem_rem[i] != '0) begin
            mem_rem[i] <= mem_rem[i] - REM_W'(1);
          end else begin
            due[i] <= 1'b1;
          end
        end
      end
      if (pop) begin
        occupied[rd_ptr] <= 1'b0;
        due[rd_ptr]      <= 1'b0;
      end
      if (push) begin
        occupied[wr_ptr] <= 1'b1;
        due[wr_ptr]      <= 1'b0;
        mem_data[wr_ptr] <= in_data_i;
        mem_rem[wr_ptr]  <= new_delay;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_delay_stream.sv
// Directed bench for rand_delay_stream: fixed delay, full/back-pressure, push+pop,
// back-to-back zero delay, asynchronous reset mid-stream and a random-traffic run.
module tb_rand_delay_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Instance A: DEPTH 4, fixed delay of 3
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;
  // Instance B: DEPTH 8, random delay 2..9
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [3:0]  b_count;
  // Instance C: DEPTH 8, zero delay
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [3:0]  c_count;

  rand_delay_stream #(.DATA_WIDTH(32), .DEPTH(4), .MIN_DELAY(3), .MAX_DELAY(15),
                      .FIXED_DELAY(1'b1), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst_ni(rst_n), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_data_i(a_in_data), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .count_o(a_count));

  rand_delay_stream #(.DATA_WIDTH(32), .DEPTH(8), .MIN_DELAY(2), .MAX_DELAY(9),
                      .FIXED_DELAY(1'b0), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst_ni(rst_n), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(b_in_data), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .count_o(b_count));

  rand_delay_stream #(.DATA_WIDTH(32), .DEPTH(8), .MIN_DELAY(0), .MAX_DELAY(0),
                      .FIXED_DELAY(1'b0), .LFSR_SEED(16'hACE1)) dut_c (
    .clk(clk), .rst_ni(rst_n), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
    .in_data_i(c_in_data), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .out_data_o(c_out_data), .count_o(c_count));

  // Reference LFSR for instance B, restarted by the same reset.
  logic [15:0] model_lfsr;

  function automatic logic [15:0] model_step(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_lfsr <= 16'hACE1;
    else        model_lfsr <= model_step(model_lfsr);
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (a_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", a_out_data); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_in_ready: got %b expected 0", b_in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_cycle_ready: got %b expected 1", a_in_ready); end
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL first_cycle_ready_c: got %b expected 1", c_in_ready); end
  endtask

  task automatic test_fixed_delay();
    @(posedge clk); #1;
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_out_valid !== (i == 4)) begin
        errors++; $display("[TB] FAIL fixed_valid[k+%0d]: got %b expected %b", i, a_out_valid, (i == 4));
      end
      if (i == 0) begin
        checks++; if (a_count !== 3'd1) begin errors++; $display("[TB] FAIL fixed_count_held: got %0d expected 1", a_count); end
      end
      if (i == 4) begin
        checks++; if (a_out_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fixed_data: got %h expected deadbeef", a_out_data); end
      end
      if (i == 5) begin
        checks++; if (a_count !== 3'd0) begin errors++; $display("[TB] FAIL fixed_count_end: got %0d expected 0", a_count); end
      end
    end
  endtask

  task automatic test_full();
    int accepted = 0;
    int got = 0;
    bit ready_pending = 1'b0;
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA000_0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_in_valid && a_in_ready) accepted++;
      @(posedge clk); #1;
      a_in_data = 32'hA000_0000 + 32'(accepted);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (accepted != 4) begin errors++; $display("[TB] FAIL full_accepted: got %0d expected 4", accepted); end
    checks++; if (a_count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", a_count); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", a_in_ready); end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (ready_pending) begin
        ready_pending = 1'b0;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_pop: got %b expected 1", a_in_ready); end
      end
      if (a_out_valid) begin
        checks++;
        if (a_out_data !== 32'hA000_0000 + 32'(got)) begin
          errors++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", got, a_out_data, 32'hA000_0000 + 32'(got));
        end
        if (got == 0) begin
          checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_during_pop: got %b expected 0", a_in_ready); end
          ready_pending = 1'b1;
        end
        got++;
      end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;
    checks++; if (got != 4) begin errors++; $display("[TB] FAIL full_drain: got %0d beats expected 4", got); end
    @(negedge clk);
    checks++; if (a_count !== 3'd0) begin errors++; $display("[TB] FAIL full_drain_count: got %0d expected 0", a_count); end
  endtask

  task automatic test_push_pop();
    logic [31:0] expq [$];
    int got = 0;
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hB000_0001;
    @(posedge clk); #1;
    a_in_data = 32'hB000_0002;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a_in_valid = 1'b1; a_in_data = 32'hB000_0003; a_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_count !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_count_before: got %0d expected 2", a_count); end
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB000_0001) begin
      errors++; $display("[TB] FAIL pushpop_head: got %b/%h expected 1/b0000001", a_out_valid, a_out_data);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_count_after: got %0d expected 2", a_count); end
    expq.push_back(32'hB000_0002);
    expq.push_back(32'hB000_0003);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 15 && expq.size() > 0; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        checks++;
        if (a_out_data !== expq[0]) begin errors++; $display("[TB] FAIL pushpop_order: got %h expected %h", a_out_data, expq[0]); end
        void'(expq.pop_front());
        got++;
      end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;
    checks++; if (got != 2) begin errors++; $display("[TB] FAIL pushpop_drain: got %0d beats expected 2", got); end
    @(negedge clk);
    checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL pushpop_empty: got count %0d valid %b expected 0/0", a_count, a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      c_out_ready = 1'b1; c_in_valid = (i < 10); c_in_data = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      checks++;
      if (c_out_valid !== (i >= 2 && i <= 11)) begin
        errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", i, c_out_valid, (i >= 2 && i <= 11));
      end
      if (i >= 2 && i <= 11) begin
        checks++;
        if (c_out_data !== 32'hC000_0000 + 32'(i - 2)) begin
          errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, c_out_data, 32'hC000_0000 + 32'(i - 2));
        end
      end
      if (i < 10) begin
        checks++; if (c_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, c_in_ready); end
      end
      if (i == 5) begin
        checks++; if (c_count !== 4'd2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", c_count); end
      end
    end
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h0000_0011;
    @(posedge clk); #1;
    b_in_data = 32'h0000_0022;
    @(posedge clk); #1;
    b_in_data = 32'h0000_0033;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_count !== 4'd3) begin errors++; $display("[TB] FAIL mid_held: got %0d expected 3", b_count); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b_count !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", b_count); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", b_out_valid); end
    checks++; if (b_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", b_in_ready); end
    checks++; if (b_out_data !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_data: got %h expected 0", b_out_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_first_ready: got %b expected 1", b_in_ready); end
    // Accepted with LFSR at 16'hE270 (one step past the seed): delay 2, valid 3 edges later.
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (b_out_valid !== (i == 3)) begin
        errors++; $display("[TB] FAIL mid_replay_valid[k+%0d]: got %b expected %b", i, b_out_valid, (i == 3));
      end
      if (i == 3) begin
        checks++; if (b_out_data !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL mid_replay_data: got %h expected cafe0001", b_out_data); end
      end
    end
    b_out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q_data [$];
    int          q_acc  [$];
    int          q_d    [$];
    bit          seen_d [10];
    int          accepted = 0;
    int          last_pop = 0;
    bit          head_seen = 1'b0;
    int          exp_edge;
    int          now;
    int          missing = 0;
    for (int v = 0; v < 10; v++) seen_d[v] = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      if (accepted < 1000) begin
        b_in_valid  = ($urandom_range(0, 1) != 0);
        b_in_data   = $urandom;
        b_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
      end
      @(negedge clk);
      now = edge_cnt;
      checks++;
      if (b_count !== 4'(q_data.size())) begin
        errors++; $display("[TB] FAIL rand_count @%0d: got %0d expected %0d", now, b_count, q_data.size());
      end
      if (head_seen && !b_out_valid) begin
        checks++; errors++; $display("[TB] FAIL rand_valid_dropped @%0d: got 0 expected 1", now);
        head_seen = 1'b0;
      end
      if (b_out_valid) begin
        checks++;
        if (q_data.size() == 0) begin
          errors++; $display("[TB] FAIL rand_spurious @%0d: got valid expected empty", now);
        end else begin
          if (b_out_data !== q_data[0]) begin
            errors++; $display("[TB] FAIL rand_data @%0d: got %h expected %h", now, b_out_data, q_data[0]);
          end
          if (!head_seen) begin
            exp_edge = q_acc[0] + 1 + q_d[0];
            if (last_pop > exp_edge) exp_edge = last_pop;
            checks++;
            if (now != exp_edge) begin
              errors++; $display("[TB] FAIL rand_latency @%0d: got release edge %0d expected %0d", now, now, exp_edge);
            end else if (exp_edge == q_acc[0] + 1 + q_d[0]) begin
              seen_d[now - q_acc[0] - 1] = 1'b1;
            end
            head_seen = 1'b1;
          end
          if (b_out_ready) begin
            last_pop = now + 1;
            void'(q_data.pop_front());
            void'(q_acc.pop_front());
            void'(q_d.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        q_data.push_back(b_in_data);
        q_acc.push_back(now + 1);
        q_d.push_back(2 + int'(model_lfsr % 16'd8));
        accepted++;
      end
      if (accepted >= 1000 && q_data.size() == 0) break;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    checks++; if (accepted < 1000) begin errors++; $display("[TB] FAIL rand_accepted: got %0d expected 1000", accepted); end
    checks++; if (q_data.size() != 0) begin errors++; $display("[TB] FAIL rand_drain: got %0d left expected 0", q_data.size()); end
    for (int v = 2; v <= 9; v++) if (!seen_d[v]) missing++;
    checks++; if (missing != 0) begin errors++; $display("[TB] FAIL rand_delay_cover: got %0d delays unseen expected 0", missing); end
  endtask

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0;
    test_reset();
    test_fixed_delay();
    test_full();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_delay_stream.md
# rand_delay_stream

Synthesizable, clock-based random-delay line for valid/ready streams; the successor to the behavioural random-delay element. Each accepted beat is held for a per-beat delay of MIN_DELAY..MAX_DELAY cycles, drawn from an internal LFSR or fixed. Beat order is preserved, and up to DEPTH beats may be in flight. Sits between a verification agent or IP port and the DUT to stress back-pressure and latency tolerance.

## Interface
- DATA_WIDTH, 32, beat width in bits (>=1)
- DEPTH, 8, in-flight entries (>=1; any integer)
- MIN_DELAY, 0, minimum added delay in cycles
- MAX_DELAY, 15, maximum added delay in cycles (>= MIN_DELAY; elaboration error otherwise)
- FIXED_DELAY, 0, 1: every beat gets exactly MIN_DELAY
- LFSR_SEED, 16'hACE1, LFSR reset value (0 replaced by 16'h0001)
- clk  input  1  clock, rising edge
- rst_ni  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid_i  input  1  upstream beat valid
- in_ready_o  output  1  upstream beat accepted when valid&ready
- in_data_i  input  DATA_WIDTH  upstream beat
- out_valid_o  output  1  head beat released
- out_ready_i  input  1  downstream ready
- out_data_o  output  DATA_WIDTH  head beat data
- count_o  output  $clog2(DEPTH+1)  entries currently held

## Operation
- Storage: circular buffer of DEPTH entries {data, remaining}; remaining width $clog2(MAX_DELAY+1). Write pointer and read pointer wrap from DEPTH-1 to 0.
- Accept: when in_valid_i & in_ready_o at a rising edge, write data and d to the tail, and increment count.
- Delay selection: d = MIN_DELAY when FIXED_DELAY=1 or MIN_DELAY==MAX_DELAY. Otherwise d = MIN_DELAY + (lfsr % (MAX_DELAY-MIN_DELAY+1)).
- LFSR: 16-bit Galois, mask 16'hB400, shift right. It advances on every cycle out of reset, whether or not a beat is accepted.
- Countdown: every cycle, each occupied entry with remaining != 0 decrements by 1. Countdown continues while the entry waits behind the head.
- Release: out_valid_o = (count != 0) & (head.remaining == 0). out_data_o = head.data.
- Pop: on out_valid_o & out_ready_i, advance the read pointer and decrement count.
- Push and pop in the same cycle leave count unchanged.
- Hold rule: once out_valid_o rises, out_valid_o and out_data_o stay stable until the pop.
- Order: strictly FIFO. A short-delay beat behind a long-delay head waits for the head (head-of-line blocking).
- Full: in_ready_o = (count < DEPTH). A pop in the same cycle does not make a full buffer ready.
- Empty: out_valid_o = 0.

## Timing
- Reset (rst_ni low, asynchronous):
  - count_o = 0, in_ready_o = 0, out_valid_o = 0, out_data_o = 0.
  - Pointers = 0, storage data and remaining = 0, lfsr = LFSR_SEED.
- First cycle after deassertion: in_ready_o = 1.
- Latency:
  - A beat accepted at edge k with delay d, on an empty buffer, asserts out_valid_o after edge k+1+d.
  - Minimum latency is 1 cycle (d = 0). Output is always registered; there is no combinational in->out path.
  - Release is never earlier than 1+d cycles after the accepting edge, and never earlier than the edge after the previous beat's pop.
- Reset mid-operation: all in-flight beats are dropped, with no partial output. The LFSR restarts from the seed, so a run is reproducible per seed.
- No output depends combinationally on in_valid_i or out_ready_i.

## Structure
- Package rand_delay_pkg holds:
  - LFSR_MASK constant (16'hB400)
  - lfsr_t typedef (logic [15:0])
  - function lfsr_next(lfsr_t)
- Sub-module rand_delay_lfsr: seed parameter, clk/rst_ni inputs, 16-bit state output.
- Top level holds the buffer, pointers, countdown and handshake logic.

## Test plan
- FIXED_DELAY=1, MIN_DELAY=3, out_ready_i=1; send a single beat 32'hDEADBEEF accepted at edge k -> out_valid_o high after edge k+4 for exactly one cycle with 32'hDEADBEEF, and count_o returns to 0.
- DEPTH=4, out_ready_i=0, in_valid_i held high -> four beats accepted, then in_ready_o=0 and count_o=4. Raise out_ready_i -> beats emerge in order. in_ready_o rises the cycle after the first pop.
- Random mode MIN_DELAY=2, MAX_DELAY=9; 1000 beats with random valid/ready:
  - every accept-to-release latency lies in [3, 10] plus head-of-line wait
  - output sequence equals input sequence
  - out_data_o stays stable while out_valid_o & !out_ready_i
  - all values 2..9 are observed
- Simultaneous push and pop at count_o=2 -> count_o stays 2, and no beat is lost or duplicated.
- Assert rst_ni low mid-stream with 3 beats held -> outputs go to reset values immediately (asynchronously). After release, the first accepted beat is the first to emerge, and the LFSR delay sequence matches that of a fresh run.
- MIN_DELAY=MAX_DELAY=0, out_ready_i=1, back-to-back in_valid_i -> one beat per cycle, 1-cycle latency, full throughput.
